// File: rtl/lfsr_prng.sv
// Fibonacci-LFSR pseudo-random word source with runtime seeding, all-zero
// lockup recovery and a one-entry valid/ready output buffer.
module lfsr_prng #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int              STEPS = 1,
  parameter int              OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_data,
  output logic [WIDTH-1:0] state_q,
  output logic             seed_zero,
  output logic             lockup
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_adv;
  logic             take;
  logic             q_is_zero;

  // STEPS single shifts unrolled into one combinational advance per draw
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEPS; i++) begin
      t = {t[WIDTH-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  always_comb begin
    q_adv     = advance(q);
    q_is_zero = (q == '0);
    take      = en & (~rnd_valid | rnd_ready) & ~seed_load;
  end

  // Priority: seed load, then lockup recovery, then a draw, then plain consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= SEED;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      seed_zero <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      seed_zero <= 1'b0;
      lockup    <= 1'b0;
      if (seed_load) begin
        q         <= (seed_in == '0) ? SEED : seed_in;
        rnd_valid <= 1'b0;
        seed_zero <= (seed_in == '0);
      end else if (q_is_zero) begin
        q      <= SEED;
        lockup <= 1'b1;
        if (rnd_valid && rnd_ready) begin
          rnd_valid <= 1'b0;
        end
      end else if (take) begin
        q         <= q_adv;
        rnd_data  <= q_adv[OUT_W-1:0];
        rnd_valid <= 1'b1;
      end else if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end

  assign state_q = q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: 8-bit main instance plus STEPS=8 and
// zero-TAPS instances for multi-step draws and lockup recovery.
module tb_lfsr_prng;

  logic       clk;
  logic       rst;

  logic       en, seed_load, rnd_ready;
  logic [7:0] seed_in;
  logic       rnd_valid, seed_zero, lockup;
  logic [7:0] rnd_data, state_q;

  logic       s_en, s_seed_load, s_ready;
  logic [7:0] s_seed_in;
  logic       s_valid, s_seed_zero, s_lockup;
  logic [7:0] s_data, s_state;

  logic       z_en, z_seed_load, z_ready;
  logic [7:0] z_seed_in;
  logic       z_valid, z_seed_zero, z_lockup;
  logic [7:0] z_data, z_state;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic       track;
  logic [255:0] seen;
  int         distinct;
  logic [7:0] mq;

  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h5A), .STEPS(1), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .state_q(state_q), .seed_zero(seed_zero), .lockup(lockup)
  );

  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h5A), .STEPS(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(s_en), .seed_load(s_seed_load), .seed_in(s_seed_in),
    .rnd_ready(s_ready), .rnd_valid(s_valid), .rnd_data(s_data),
    .state_q(s_state), .seed_zero(s_seed_zero), .lockup(s_lockup)
  );

  // A zero feedback mask shifts the state down to all-zero, exercising lockup
  lfsr_prng #(.WIDTH(8), .TAPS(8'h00), .SEED(8'h5A), .STEPS(1), .OUT_W(8)) dutz (
    .clk(clk), .rst(rst), .en(z_en), .seed_load(z_seed_load), .seed_in(z_seed_in),
    .rnd_ready(z_ready), .rnd_valid(z_valid), .rnd_data(z_data),
    .state_q(z_state), .seed_zero(z_seed_zero), .lockup(z_lockup)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic sl, input logic [7:0] si,
                               input logic rdy);
    en        = e;
    seed_load = sl;
    seed_in   = si;
    rnd_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    track     = 1'b0;
    seen      = '0;
    distinct  = 0;
    rst       = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    s_en = 1'b0; s_seed_load = 1'b0; s_seed_in = 8'h00; s_ready = 1'b0;
    z_en = 1'b0; z_seed_load = 1'b0; z_seed_in = 8'h00; z_ready = 1'b0;

    // Scoreboard monitor: pops one expected word per handshake on the main DUT
    fork
      forever begin
        @(negedge clk);
        if (!rst && rnd_valid && rnd_ready) begin
          if (track) begin
            if (!seen[rnd_data]) distinct++;
            seen[rnd_data] = 1'b1;
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_extra: got %0h expected no word", rnd_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rnd_data !== e) begin
              errors++;
              $display("[TB] FAIL scoreboard_word: got %0h expected %0h", rnd_data, e);
            end
          end
        end
      end
    join_none

    repeat (2) stepCycle();
    checkOutput("reset_valid", {31'd0, rnd_valid}, 32'd0);
    checkOutput("reset_state", {24'd0, state_q}, 32'h5A);
    checkOutput("reset_data", {24'd0, rnd_data}, 32'h00);
    checkOutput("reset_pulses", {30'd0, seed_zero, lockup}, 32'd0);
    rst = 1'b0;

    // First word with consumer stalled, then streaming with ready high
    exp_q.push_back(8'hB4);
    exp_q.push_back(8'h69);
    mq = 8'h69;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("first_valid", {31'd0, rnd_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_data", {24'd0, rnd_data}, 32'hB4);
      checkOutput("hold_state", {24'd0, state_q}, 32'hB4);
      stepCycle();
    end
    for (int i = 0; i < 4; i++) begin
      mq = lfsr_step(mq);
      exp_q.push_back(mq);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("stream_no_bubble", {31'd0, rnd_valid}, 32'd1);
    end
    mq = lfsr_step(mq);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("stream_last_data", {24'd0, rnd_data}, {24'd0, mq});
    checkOutput("stream_last_state", {24'd0, state_q}, {24'd0, mq});

    // Seed load flushes the buffered word without ready
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
    stepCycle();
    checkOutput("seed_state", {24'd0, state_q}, 32'h01);
    checkOutput("seed_flush", {31'd0, rnd_valid}, 32'd0);
    checkOutput("seed_nonzero_pulse", {31'd0, seed_zero}, 32'd0);
    exp_q.push_back(8'h02);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    stepCycle();
    checkOutput("seed_draw_valid", {31'd0, rnd_valid}, 32'd1);
    checkOutput("seed_draw_data", {24'd0, rnd_data}, 32'h02);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycle();
    checkOutput("en_low_drain", {31'd0, rnd_valid}, 32'd0);
    checkOutput("en_low_no_advance", {24'd0, state_q}, 32'h02);

    // Zero seed is replaced by SEED with a single-cycle flag
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    stepCycle();
    checkOutput("zero_seed_state", {24'd0, state_q}, 32'h5A);
    checkOutput("zero_seed_pulse", {31'd0, seed_zero}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("zero_seed_pulse_end", {31'd0, seed_zero}, 32'd0);

    // Full period: 255 distinct non-zero words, state returns to SEED
    track = 1'b1;
    mq = 8'h5A;
    for (int i = 0; i < 255; i++) begin
      mq = lfsr_step(mq);
      exp_q.push_back(mq);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (255) stepCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycle();
    track = 1'b0;
    checkOutput("period_distinct", distinct, 32'd255);
    checkOutput("period_no_zero", {31'd0, seen[0]}, 32'd0);
    checkOutput("period_state", {24'd0, state_q}, 32'h5A);
    checkOutput("period_drained", {31'd0, rnd_valid}, 32'd0);
    checkOutput("scoreboard_drain", exp_q.size(), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Lockup: zero taps drain the state to 0 after seven draws
    z_en = 1'b1; z_ready = 1'b1;
    repeat (7) stepCycle();
    checkOutput("lock_zero_state", {24'd0, z_state}, 32'h00);
    checkOutput("lock_zero_data", {24'd0, z_data}, 32'h00);
    checkOutput("lock_not_yet", {31'd0, z_lockup}, 32'd0);
    stepCycle();
    checkOutput("lock_pulse", {31'd0, z_lockup}, 32'd1);
    checkOutput("lock_state", {24'd0, z_state}, 32'h5A);
    checkOutput("lock_no_word", {31'd0, z_valid}, 32'd0);
    stepCycle();
    checkOutput("lock_pulse_end", {31'd0, z_lockup}, 32'd0);
    checkOutput("lock_resume", {24'd0, z_data}, 32'hB4);
    z_en = 1'b0; z_ready = 1'b0;

    // STEPS=8: eight single steps per word, then async reset mid-burst
    s_en = 1'b1; s_ready = 1'b1;
    stepCycle();
    checkOutput("steps8_first", {24'd0, s_data}, 32'h45);
    checkOutput("steps8_state", {24'd0, s_state}, 32'h45);
    mq = 8'h45;
    for (int i = 0; i < 8; i++) mq = lfsr_step(mq);
    stepCycle();
    checkOutput("steps8_second", {24'd0, s_data}, {24'd0, mq});
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("midreset_state", {24'd0, s_state}, 32'h5A);
    #2 rst = 1'b0;
    stepCycle();
    checkOutput("post_reset_word", {24'd0, s_data}, 32'h45);
    s_en = 1'b0; s_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
